// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: finds frame alignment from the slot-0 marker and fans the slots out to four outputs.
// Outputs publish one clk after each slot-3 beat, and only while locked; din_valid=0 stalls every piece of state.
module tdm_demux4 #(
    parameter int WIDTH      = 1,
    parameter int LOCK_COUNT = 2,
    parameter int MISS_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             fsync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [GW-1:0]    good_cnt;
    logic [MW-1:0]    miss_cnt;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;

    logic          at_slot0;
    logic          marker_err;
    logic [GW-1:0] good_inc;
    logic [MW-1:0] miss_inc;
    logic          good_hit;
    logic          miss_hit;

    // A marker error is a missing marker at slot 0 or a stray marker anywhere else.
    always_comb begin
        at_slot0   = (slot == 2'd0);
        marker_err = at_slot0 ? ~fsync : fsync;
        good_inc   = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
        miss_inc   = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MW'(1);
        good_hit   = (good_inc == GOOD_MAX);
        miss_hit   = (miss_inc == MISS_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            shadow0  <= din;
                            slot     <= 2'd1;
                            good_cnt <= GW'(1);
                            state    <= CHECK;
                        end
                    end

                    CHECK: begin
                        case (slot)
                            2'd0:    shadow0 <= din;
                            2'd1:    shadow1 <= din;
                            2'd2:    shadow2 <= din;
                            default: ;
                        endcase
                        slot <= slot + 2'd1;
                        if (marker_err) begin
                            // A stray marker is not reused as slot 0; HUNT waits for a fresh one.
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            slot     <= 2'd0;
                            good_cnt <= '0;
                        end else if (at_slot0) begin
                            good_cnt <= good_inc;
                            if (good_hit) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end
                    end

                    LOCKED: begin
                        case (slot)
                            2'd0:    shadow0 <= din;
                            2'd1:    shadow1 <= din;
                            2'd2:    shadow2 <= din;
                            default: ;
                        endcase
                        slot <= slot + 2'd1;
                        if (marker_err && miss_hit) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            slot     <= 2'd0;
                            miss_cnt <= '0;
                            good_cnt <= '0;
                        end else begin
                            // Sub-limit errors flywheel: slot counter keeps running, frame still publishes.
                            if (marker_err) begin
                                sync_err <= 1'b1;
                                miss_cnt <= miss_inc;
                            end else if (at_slot0) begin
                                miss_cnt <= '0;
                            end
                            if (slot == 2'd3) begin
                                out_a       <= shadow0;
                                out_b       <= shadow1;
                                out_c       <= shadow2;
                                out_d       <= din;
                                frame_valid <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        slot     <= 2'd0;
                        good_cnt <= '0;
                        miss_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4:1 time-division link driven by the team's 4:1 mux.
- Takes one time-multiplexed sample per valid beat plus a frame-sync marker on slot 0.
- Recovers frame alignment, then distributes slots 0..3 to four registered outputs.
- All four outputs update together once per complete frame.

Parameters:
- WIDTH, 1, bits per sample/channel.
- LOCK_COUNT, 2, consecutive correctly placed markers needed to declare lock. Legal range ≥2.
- MISS_LIMIT, 2, consecutive marker errors in LOCKED that force return to HUNT. Legal range ≥1.

Ports:
- clk  in  1  single clock; everything samples on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  multiplexed sample.
- din_valid  in  1  din/fsync qualify; no state advances when low.
- fsync  in  1  frame marker; high with the slot-0 sample.
- out_a  out  WIDTH  slot 0 of last published frame.
- out_b  out  WIDTH  slot 1 of last published frame.
- out_c  out  WIDTH  slot 2 of last published frame.
- out_d  out  WIDTH  slot 3 of last published frame.
- frame_valid  out  1  one-cycle pulse when out_a..out_d update.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse per marker error in CHECK or LOCKED.

Behaviour:
- Reset (synchronous, active-high rst):
  - All outputs 0; state HUNT; slot counter, good_cnt, miss_cnt and shadow registers 0.
  - A partial frame is discarded; rst overrides all other inputs in the same cycle.
- Beat: a cycle with din_valid=1. Cycles with din_valid=0 change nothing; fsync is ignored in them.
- Slot counter: 2-bit, advances 0→1→2→3→0 per beat. Each beat writes din into shadow[slot].
- HUNT:
  - locked=0; no publishing.
  - A beat with fsync=1 is taken as slot 0 (counter forced; next beat is slot 1); good_cnt=1; go CHECK.
  - Beats without fsync are ignored.
- CHECK:
  - At each slot-0 beat with fsync=1: good_cnt+1.
  - If good_cnt reaches LOCK_COUNT, go LOCKED. The frame starting at that beat is the first one published.
  - fsync=0 at a slot-0 beat, or fsync=1 at slot 1..3: pulse sync_err, go HUNT.
  - An fsync=1 at slot 1..3 is not re-used as a new slot 0; HUNT waits for the next marker.
- LOCKED:
  - locked=1.
  - Correct marker at slot 0: miss_cnt=0.
  - Marker error (missing at slot 0, or present at slot 1..3): pulse sync_err, miss_cnt+1. The slot counter is NOT realigned (flywheel).
  - If miss_cnt reaches MISS_LIMIT: go HUNT, locked=0 next cycle, and the current frame is discarded.
  - Each slot-3 beat completes a frame. The next cycle, out_a..out_d take shadow[0..3] and frame_valid=1 for one cycle. This applies even if that frame had one (sub-limit) marker error.
- Latency: outputs and frame_valid are registered, one clk after the slot-3 beat. locked and sync_err are registered, one clk after the deciding beat.
- Between frames, outputs hold their last published values. Leaving LOCKED does not clear them.
- Simultaneous events:
  - A miss that reaches MISS_LIMIT on a slot-3 beat suppresses that frame's publish.
  - A slot-3 beat with fsync=1 in LOCKED counts as a miss, and the frame still publishes if below the limit.
- Counters saturate at their limit values; no wrap.

Test Plan:
1. Reset then stream WIDTH=1, fsync on beats 0,4,8, data per frame 1,0,1,1 → locked rises the cycle after beat 4; frame_valid pulses the cycle after beat 7 with a,b,c,d=1,0,1,1; the next pulse follows beat 11; outputs are 0 before the first pulse.
2. Locked stream with din_valid low for 3 cycles mid-frame (after slot 1) → slot counter holds, frame publishes correct a..d once, with frame_valid delayed by 3 cycles.
3. Locked, drop fsync at one slot-0 beat (MISS_LIMIT=2) → one sync_err pulse, locked stays 1, frame still published; the next correct marker clears miss_cnt. Drop two consecutive → locked=0 the cycle after the second miss, no publish for that frame.
4. HUNT, fsync at beat 0 then at beat 2 (wrong slot) → sync_err pulse, back to HUNT, no lock; a fresh marker at beat 5, then at beat 9 → lock after beat 9.
5. Assert rst for 1 cycle mid-frame while locked → all outputs 0, locked=0; the partial frame is never published; re-lock requires LOCK_COUNT markers.
6. WIDTH=8, LOCK_COUNT=3, slots 0xA5,0x3C,0xFF,0x00 → lock only after the third marker; a..d=0xA5,0x3C,0xFF,0x00.
